lock_sequencer: RTL and testbench

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

---
 rtl/lock_sequencer.sv | 153 +++++++++++++++
 tb/tb_lock_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer: four-digit keypad lock sequencer.
//   Steps an expected-digit position (which_state) forward on each correct
//   key press. After four correct digits it opens the lock for RELOCK_CYCLES
//   cycles. After MAX_FAILS wrong digits it ignores the keypad for
//   LOCKOUT_CYCLES cycles.
// Ports:
//   clk5        in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   keycode     in   [4:0] keypad code (bit4 = key held, 5'b11100 = Clear)
//   digit_ok    in   external comparator: keycode matches digit at which_state
//   which_state out  [2:0] expected digit position 1..4, 0 when not in entry
//   unlock      out  lock open
//   locked_out  out  keypad ignored after too many failures
//   fail_count  out  [1:0] wrong digits since last open, lockout or reset
module lock_sequencer #(
  parameter int RELOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 100,
  parameter int MAX_FAILS      = 3
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [4:0] keycode,
  input  logic       digit_ok,
  output logic [2:0] which_state,
  output logic       unlock,
  output logic       locked_out,
  output logic [1:0] fail_count
);

  localparam int MAX_CYC = (RELOCK_CYCLES > LOCKOUT_CYCLES) ? RELOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] RELOCK_LOAD  = TW'(RELOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ZERO   = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAILS);
  localparam logic [4:0]    KEY_CLEAR    = 5'b11100;

  typedef enum logic [1:0] {
    ENTRY   = 2'b00,
    OPEN    = 2'b01,
    LOCKOUT = 2'b10
  } state_t;

  state_t        state_r;
  logic [2:0]    pos_r;
  logic [TW-1:0] timer_r;
  logic          key_prev_r;

  logic          press_s;
  logic          is_clear_s;
  logic [1:0]    fail_next_s;

  // A press is the rising edge of the key-held bit, so a held key counts once.
  assign press_s     = keycode[4] & ~key_prev_r;
  assign is_clear_s  = (keycode == KEY_CLEAR);
  // Cannot wrap: entry always leaves for lockout once the limit is reached.
  assign fail_next_s = fail_count + 2'd1;

  // Key-held history; reset to 1 so a key held across reset release is not a press.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      key_prev_r <= 1'b1;
    end else begin
      key_prev_r <= keycode[4];
    end
  end

  // Main sequencer: state, position, timer and all registered outputs.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_r     <= ENTRY;
      pos_r       <= 3'd1;
      timer_r     <= TIMER_ZERO;
      which_state <= 3'b001;
      unlock      <= 1'b0;
      locked_out  <= 1'b0;
      fail_count  <= 2'd0;
    end else begin
      case (state_r)
        ENTRY: begin
          if (press_s) begin
            if (is_clear_s) begin
              pos_r       <= 3'd1;
              which_state <= 3'b001;
            end else if (digit_ok) begin
              if (pos_r < 3'd4) begin
                pos_r       <= pos_r + 3'd1;
                which_state <= pos_r + 3'd1;
              end else begin
                state_r     <= OPEN;
                pos_r       <= 3'd1;
                fail_count  <= 2'd0;
                timer_r     <= RELOCK_LOAD;
                which_state <= 3'b000;
                unlock      <= 1'b1;
              end
            end else begin
              pos_r      <= 3'd1;
              fail_count <= fail_next_s;
              if (fail_next_s == FAIL_LIMIT) begin
                state_r     <= LOCKOUT;
                timer_r     <= LOCKOUT_LOAD;
                which_state <= 3'b000;
                locked_out  <= 1'b1;
              end else begin
                which_state <= 3'b001;
              end
            end
          end
        end

        OPEN: begin
          // Clear relocks early; otherwise leave on the edge that sees timer 0.
          if ((press_s && is_clear_s) || (timer_r == TIMER_ZERO)) begin
            state_r     <= ENTRY;
            pos_r       <= 3'd1;
            timer_r     <= TIMER_ZERO;
            which_state <= 3'b001;
            unlock      <= 1'b0;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end

        LOCKOUT: begin
          // Keypad fully ignored here, Clear included.
          if (timer_r == TIMER_ZERO) begin
            state_r     <= ENTRY;
            pos_r       <= 3'd1;
            which_state <= 3'b001;
            locked_out  <= 1'b0;
            fail_count  <= 2'd0;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end

        default: begin
          state_r     <= ENTRY;
          pos_r       <= 3'd1;
          timer_r     <= TIMER_ZERO;
          which_state <= 3'b001;
          unlock      <= 1'b0;
          locked_out  <= 1'b0;
          fail_count  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer: driver pushes the reference model's expected
// outputs into a queue each cycle; a monitor pops and compares after each edge.
module tb_lock_sequencer;

  localparam int RELOCK  = 50;
  localparam int LOCKOUT = 100;
  localparam int MAXF    = 3;
  localparam logic [4:0] CLR = 5'b11100;

  logic       clk5 = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] keycode = 5'd0;
  logic       digit_ok = 1'b0;
  logic [2:0] which_state;
  logic       unlock;
  logic       locked_out;
  logic [1:0] fail_count;

  always #5 clk5 = ~clk5;

  lock_sequencer #(
    .RELOCK_CYCLES(RELOCK),
    .LOCKOUT_CYCLES(LOCKOUT),
    .MAX_FAILS(MAXF)
  ) dut (
    .clk5(clk5),
    .reset(reset),
    .keycode(keycode),
    .digit_ok(digit_ok),
    .which_state(which_state),
    .unlock(unlock),
    .locked_out(locked_out),
    .fail_count(fail_count)
  );

  // Reference model: mode 0 = entry, 1 = open, 2 = lockout.
  int m_mode  = 0;
  int m_pos   = 1;
  int m_fails = 0;
  int m_left  = 0;
  bit m_prev  = 1'b1;

  int checks = 0;
  int fails  = 0;
  logic [6:0] exp_q[$];

  function automatic logic [6:0] model_out();
    logic [2:0] ws;
    ws = (m_mode == 0) ? 3'(m_pos) : 3'b000;
    return {ws, (m_mode == 1), (m_mode == 2), 2'(m_fails)};
  endfunction

  task automatic model_step(input logic [4:0] k, input logic ok, input logic r);
    bit press;
    if (r) begin
      m_mode = 0; m_pos = 1; m_fails = 0; m_left = 0; m_prev = 1'b1;
      return;
    end
    press  = k[4] && !m_prev;
    m_prev = k[4];
    if (m_mode == 0) begin
      if (press) begin
        if (k == CLR) m_pos = 1;
        else if (ok) begin
          if (m_pos < 4) m_pos = m_pos + 1;
          else begin m_mode = 1; m_left = RELOCK; m_pos = 1; m_fails = 0; end
        end else begin
          m_pos = 1;
          m_fails = m_fails + 1;
          if (m_fails == MAXF) begin m_mode = 2; m_left = LOCKOUT; end
        end
      end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if ((press && k == CLR) || m_left == 0) begin m_mode = 0; m_pos = 1; end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_mode = 0; m_pos = 1; m_fails = 0; end
    end
  endtask

  task automatic check_outputs(input logic [6:0] e, input string tag);
    logic [6:0] got;
    got = {which_state, unlock, locked_out, fail_count};
    checks++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s t=%0t: got ws=%b unlock=%b locked_out=%b fail_count=%0d, expected ws=%b unlock=%b locked_out=%b fail_count=%0d",
               tag, $time, got[6:4], got[3], got[2], got[1:0], e[6:4], e[3], e[2], e[1:0]);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  always @(posedge clk5) begin
    logic [6:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_outputs(e, "cycle");
    end
  end

  task automatic step(input logic [4:0] k, input logic ok, input logic r);
    @(negedge clk5);
    keycode  = k;
    digit_ok = ok;
    reset    = r;
    model_step(k, ok, r);
    exp_q.push_back(model_out());
    if (r) begin
      #1;
      check_outputs(model_out(), "async_reset");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step({1'b0, 4'($urandom)}, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Hold a key for 'hold' cycles (digit_ok only meaningful in the first), then release.
  task automatic press(input logic [4:0] k, input logic ok, input int hold);
    step(k, ok, 1'b0);
    for (int i = 1; i < hold; i++) step(k, 1'($urandom_range(0, 1)), 1'b0);
    step(5'b00000, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic do_reset(input int n, input logic [4:0] k);
    for (int i = 0; i < n; i++) step(k, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset(3, 5'b00000);
    idle(2);

    // Four correct digits -> open for RELOCK cycles, then back to entry.
    press(5'b10001, 1'b1, 1); press(5'b10010, 1'b1, 2);
    press(5'b10011, 1'b1, 1); press(5'b10100, 1'b1, 3);
    idle(60);

    // Two correct digits, Clear, then four correct digits.
    press(5'b10001, 1'b1, 1); press(5'b10010, 1'b1, 1);
    press(CLR, 1'b1, 1);
    for (int i = 0; i < 4; i++) press(5'b10101, 1'b1, 1);
    idle(55);

    // Three wrong digits -> lockout; presses inside the window are ignored.
    for (int i = 0; i < 3; i++) press(5'b10110, 1'b0, 1);
    press(CLR, 1'b1, 1); press(5'b10001, 1'b1, 2); press(5'b10010, 1'b0, 1);
    idle(100);

    // Held key advances exactly one position.
    press(5'b10111, 1'b1, 20);
    press(CLR, 1'b0, 1);

    // Clear early in OPEN relocks on the next edge.
    for (int i = 0; i < 4; i++) press(5'b11000, 1'b1, 1);
    idle(8);
    press(CLR, 1'b0, 1);
    idle(3);

    // Reset mid-lockout with a key held through release: no press counted.
    for (int i = 0; i < 3; i++) press(5'b11001, 1'b0, 1);
    idle(30);
    do_reset(2, 5'b11001);
    for (int i = 0; i < 5; i++) step(5'b11001, 1'b1, 1'b0);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1 + $urandom_range(0, 1), {1'($urandom_range(0, 1)), 4'($urandom)});
      end else begin
        logic [4:0] k;
        k = ($urandom_range(0, 5) == 0) ? CLR : {1'b1, 4'($urandom)};
        press(k, 1'($urandom_range(0, 4) != 0), 1 + $urandom_range(0, 2));
        idle($urandom_range(0, 2));
      end
    end

    repeat (3) @(posedge clk5);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
